// File: rtl/comb_stack_pkg.sv
// Shared defaults and entry layout for the combination-recursion stack.
// Used by comb_stack, its storage RAM, and the recursion controller/datapath.
package comb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 32;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

  typedef struct packed {
    logic [WIDTH_DEF-1:0] n;
    logic [WIDTH_DEF-1:0] k;
  } entry_t;

endpackage

// File: rtl/comb_stack_ram.sv
// Stack storage: DEPTH x W, synchronous write, registered read port.
// Only the read register is reset; the array contents are left undefined.
module stack_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read sees the pre-edge contents even when the same address is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/comb_stack.sv
// LIFO stack of {n, k} entries: pointer, status/error flags and control.
// Optional high-water-mark output max_count when COMB_STACK_HWM_EN is defined.
module comb_stack
  import comb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] din_n,
  input  logic [WIDTH-1:0] din_k,
  output logic [WIDTH-1:0] dout_n,
  output logic [WIDTH-1:0] dout_k,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
`ifdef COMB_STACK_HWM_EN
  output logic [CW-1:0]    max_count,
`endif
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = CW - 1;

  logic [CW-1:0]      count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic               do_replace, do_insert, do_remove, do_read;
  logic               we;
  logic [AW-1:0]      head_addr, waddr;
  logic [2*WIDTH-1:0] rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign head_addr = count_q[AW-1:0] - AW'(1);

  // Push+pop on a non-empty stack overwrites the head in place.
  always_comb begin
    do_replace = 1'b0;
    do_insert  = 1'b0;
    do_remove  = 1'b0;
    do_read    = 1'b0;
    if (!clr) begin
      do_replace = push & pop & !empty;
      do_insert  = push & !(pop & !empty) & !full;
      do_remove  = pop & !push & !empty;
      do_read    = top & !empty;
    end
  end

  assign we    = do_replace | do_insert;
  assign waddr = do_replace ? head_addr : count_q[AW-1:0];

  always_comb begin
    count_d = count_q;
    valid_d = do_read;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (do_insert)      count_d = count_q + CW'(1);
      else if (do_remove) count_d = count_q - CW'(1);
      if (push & !pop & full)               ovf_d = 1'b1;
      if ((pop & !push & empty) | (top & empty)) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef COMB_STACK_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (clr)                  hwm_d = '0;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hwm_q <= '0;
    else      hwm_q <= hwm_d;
  end

  assign max_count = hwm_q;
`endif

  stack_ram #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata ({din_n, din_k}),
    .re    (do_read),
    .raddr (head_addr),
    .rdata (rdata)
  );

  assign dout_n     = rdata[2*WIDTH-1:WIDTH];
  assign dout_k     = rdata[WIDTH-1:0];
  assign dout_valid = valid_q;
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_comb_stack.sv
// Directed self-checking bench for comb_stack (default parameters).
// Exercises max_count too when built with COMB_STACK_HWM_EN.
module tb_comb_stack;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst, clr, push, pop, top;
  logic [W-1:0]  din_n, din_k;
  logic [W-1:0]  dout_n, dout_k;
  logic          dout_valid, empty, full, overflow, underflow;
  logic [CW-1:0] count;
`ifdef COMB_STACK_HWM_EN
  logic [CW-1:0] max_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  comb_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .push       (push),
    .pop        (pop),
    .top        (top),
    .din_n      (din_n),
    .din_k      (din_k),
    .dout_n     (dout_n),
    .dout_k     (dout_k),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
`ifdef COMB_STACK_HWM_EN
    .max_count  (max_count),
`endif
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of operation; returns 1 time unit after the sampling edge.
  task automatic op(input logic ps, input logic pp, input logic tp, input logic c,
                    input logic [W-1:0] n, input logic [W-1:0] k);
    push = ps; pop = pp; top = tp; clr = c; din_n = n; din_k = k;
    @(posedge clk);
    #1;
    push = 0; pop = 0; top = 0; clr = 0; din_n = '0; din_k = '0;
  endtask

  initial begin
    rst = 0; clr = 0; push = 0; pop = 0; top = 0; din_n = '0; din_k = '0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    check("rst_dout",  32'({dout_n, dout_k}), 0);
    check("rst_valid", 32'(dout_valid), 0);
    check("rst_flags", 32'({overflow, underflow}), 0);
    rst = 1;

    op(1, 0, 0, 0, 5, 2);
    op(1, 0, 0, 0, 4, 2);
    op(1, 0, 0, 0, 4, 1);
    check("push3_count", 32'(count), 3);
    op(0, 0, 1, 0, 0, 0);
    check("top_dout",  32'({dout_n, dout_k}), 32'h0401);
    check("top_valid", 32'(dout_valid), 1);
    op(0, 0, 0, 0, 0, 0);
    check("valid_pulse_end", 32'(dout_valid), 0);
    check("dout_hold", 32'({dout_n, dout_k}), 32'h0401);

    repeat (3) op(0, 1, 0, 0, 0, 0);
    check("pop3_count", 32'(count), 0);
    check("pop3_empty", 32'(empty), 1);
    check("pop3_unf",   32'(underflow), 0);
    op(0, 1, 0, 0, 0, 0);
    check("pop4_unf",   32'(underflow), 1);
    check("pop4_count", 32'(count), 0);
    op(0, 0, 1, 0, 0, 0);
    check("top_empty_valid", 32'(dout_valid), 0);
    check("top_empty_dout",  32'({dout_n, dout_k}), 32'h0401);
    op(0, 0, 0, 1, 0, 0);
    check("clr_unf", 32'(underflow), 0);

    for (int i = 0; i < D; i++) op(1, 0, 0, 0, W'(i), W'(i + 1));
    check("fill_count", 32'(count), D);
    check("fill_full",  32'(full), 1);
    check("fill_ovf",   32'(overflow), 0);
    op(1, 0, 0, 0, 9, 9);
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_count", 32'(count), D);
    op(0, 0, 1, 0, 0, 0);
    check("ovf_top", 32'({dout_n, dout_k}), 32'h1F20);
    op(0, 0, 0, 0, 0, 0);
    check("ovf_sticky", 32'(overflow), 1);
    op(1, 1, 0, 0, 8'hAA, 8'h55);
    check("full_replace_count", 32'(count), D);
    op(0, 0, 1, 0, 0, 0);
    check("full_replace_top", 32'({dout_n, dout_k}), 32'hAA55);
    op(0, 0, 0, 1, 0, 0);
    check("clr_count", 32'(count), 0);
    check("clr_flags", 32'({overflow, underflow}), 0);

    op(1, 0, 0, 0, 3, 1);
    op(1, 1, 0, 0, 2, 0);
    check("replace_count", 32'(count), 1);
    op(0, 0, 1, 0, 0, 0);
    check("replace_top", 32'({dout_n, dout_k}), 32'h0200);
    op(1, 0, 1, 0, 7, 7);
    check("top_push_old", 32'({dout_n, dout_k}), 32'h0200);
    check("top_push_count", 32'(count), 2);
    op(0, 1, 1, 0, 0, 0);
    check("top_pop_old", 32'({dout_n, dout_k}), 32'h0707);
    check("top_pop_count", 32'(count), 1);
    op(1, 0, 1, 1, 1, 1);
    check("clr_prio_count", 32'(count), 0);
    check("clr_prio_valid", 32'(dout_valid), 0);
    op(1, 1, 0, 0, 6, 6);
    check("pp_empty_count", 32'(count), 1);
    check("pp_empty_unf",   32'(underflow), 0);

    op(0, 0, 0, 1, 0, 0);
    op(1, 0, 0, 0, 1, 2);
    op(1, 0, 0, 0, 3, 4);
    op(1, 0, 1, 0, 5, 6);
    check("pre_rst_dout", 32'({dout_n, dout_k}), 32'h0304);
    #2 rst = 0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_dout",  32'({dout_n, dout_k}), 0);
    check("async_rst_valid", 32'(dout_valid), 0);
    #3 rst = 1;
    @(posedge clk); #1;
    op(1, 0, 0, 0, 8'h11, 8'h22);
    op(0, 0, 1, 0, 0, 0);
    check("post_rst_count", 32'(count), 1);
    check("post_rst_top",   32'({dout_n, dout_k}), 32'h1122);
    op(0, 1, 0, 0, 0, 0);
    op(0, 1, 0, 0, 0, 0);
    check("err_unf", 32'(underflow), 1);
    op(0, 0, 0, 1, 0, 0);
    check("err_clr", 32'({overflow, underflow}), 0);

`ifdef COMB_STACK_HWM_EN
    repeat (4) op(1, 0, 0, 0, 1, 1);
    repeat (2) op(0, 1, 0, 0, 0, 0);
    op(1, 0, 0, 0, 1, 1);
    check("hwm_count", 32'(count), 3);
    check("hwm_max", 32'(max_count), 4);
    op(0, 0, 0, 1, 0, 0);
    check("hwm_clr", 32'(max_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
